// File: rtl/alu_div_seq_if.sv
// Handshake and result bundle for the sequential divider.
interface alu_div_seq_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, signed_op, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, signed_op, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/alu_div_seq.sv
// Restoring divider, one quotient bit per clock, signed or unsigned operands.
// Magnitudes are divided unsigned; signs are reapplied in a single fix-up cycle.
module alu_div_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_div_seq_if.slave        bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_count;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_dq;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_dd_raw;
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_dz;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remd;
  logic             r_dz_out;

  logic             w_dd_neg;
  logic             w_ds_neg;
  logic [WIDTH-1:0] w_dd_mag;
  logic [WIDTH-1:0] w_ds_mag;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH+1:0] w_trial;
  logic             w_borrow;

  always_comb begin
    w_dd_neg = bus.signed_op & bus.dividend[WIDTH-1];
    w_ds_neg = bus.signed_op & bus.divisor[WIDTH-1];
    // Negating the most negative value yields 2^(WIDTH-1), correct as an unsigned magnitude.
    w_dd_mag = w_dd_neg ? (~bus.dividend + 1'b1) : bus.dividend;
    w_ds_mag = w_ds_neg ? (~bus.divisor + 1'b1) : bus.divisor;
    w_shift  = {r_rem[WIDTH-1:0], r_dq[WIDTH-1]};
    w_trial  = {1'b0, w_shift} - {2'b00, r_dvs};
    w_borrow = w_trial[WIDTH+1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_rem    <= '0;
      r_dq     <= '0;
      r_dvs    <= '0;
      r_dd_raw <= '0;
      r_q_neg  <= 1'b0;
      r_r_neg  <= 1'b0;
      r_dz     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_quot   <= '0;
      r_remd   <= '0;
      r_dz_out <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state  <= S_CALC;
            r_count  <= '0;
            r_rem    <= '0;
            r_dq     <= w_dd_mag;
            r_dvs    <= w_ds_mag;
            r_dd_raw <= bus.dividend;
            r_q_neg  <= w_dd_neg ^ w_ds_neg;
            r_r_neg  <= w_dd_neg;
            r_dz     <= (bus.divisor == '0);
            r_busy   <= 1'b1;
          end
        end
        S_CALC: begin
          r_rem   <= w_borrow ? w_shift : w_trial[WIDTH:0];
          r_dq    <= {r_dq[WIDTH-2:0], ~w_borrow};
          r_count <= r_count + 1'b1;
          if (r_count == CW'(WIDTH - 1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (r_dz) begin
            r_quot <= '1;
            r_remd <= r_dd_raw;
          end else begin
            r_quot <= r_q_neg ? (~r_dq + 1'b1) : r_dq;
            r_remd <= r_r_neg ? (~r_rem[WIDTH-1:0] + 1'b1) : r_rem[WIDTH-1:0];
          end
          r_dz_out <= r_dz;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_count  <= '0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_remd;
  assign bus.div_by_zero = r_dz_out;
endmodule

// File: tb/tb_alu_div_seq.sv
// Directed and randomized bench for alu_div_seq against an arithmetic reference model.
module tb_alu_div_seq;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_div_seq_if #(.WIDTH(16)) bus ();

  alu_div_seq #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: truncating division on integers; C-style % takes the dividend's sign.
  function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic s,
                                output logic [15:0] q, output logic [15:0] r, output logic dz);
    int sa;
    int sb;
    if (b == 16'h0) begin
      q = 16'hFFFF; r = a; dz = 1'b1;
    end else if (s) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      q = 16'(sa / sb); r = 16'(sa % sb); dz = 1'b0;
    end else begin
      q = a / b; r = a % b; dz = 1'b0;
    end
  endfunction

  task automatic do_div(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input int inj, input string tag);
    logic [15:0] eq, er, pq, pr;
    logic        edz, pdz, stable;
    int          lat;
    model(a, b, s, eq, er, edz);
    @(negedge clk);
    pq = bus.quotient; pr = bus.remainder; pdz = bus.div_by_zero;
    bus.start = 1'b1; bus.signed_op = s; bus.dividend = a; bus.divisor = b;
    @(posedge clk); #1;
    chk({tag, "_busy_after_accept"}, 32'(bus.busy), 32'd1);
    lat = 0;
    stable = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      bus.start     = (i == inj);
      bus.dividend  = 16'($urandom);
      bus.divisor   = 16'($urandom);
      bus.signed_op = 1'($urandom);
      @(posedge clk); #1;
      if (bus.done) begin
        lat = i;
        break;
      end
      if (bus.quotient !== pq || bus.remainder !== pr || bus.div_by_zero !== pdz) stable = 1'b0;
    end
    bus.start = 1'b0;
    chk({tag, "_latency"}, 32'(lat), 32'd17);
    chk({tag, "_stable_while_busy"}, 32'(stable), 32'd1);
    chk({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    chk({tag, "_quotient"}, 32'(bus.quotient), 32'(eq));
    chk({tag, "_remainder"}, 32'(bus.remainder), 32'(er));
    chk({tag, "_dz"}, 32'(bus.div_by_zero), 32'(edz));
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        rs;
    bit          saw_done;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.signed_op = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_q", 32'(bus.quotient), 32'd0);
    chk("rst_r", 32'(bus.remainder), 32'd0);
    chk("rst_dz", 32'(bus.div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_div(16'h0064, 16'h0007, 1'b0, 0, "u100d7");
    chk("u100d7_q_const", 32'(bus.quotient), 32'h000E);
    do_div(16'hFF9C, 16'h0007, 1'b1, 0, "sm100d7");
    chk("sm100d7_r_const", 32'(bus.remainder), 32'hFFFE);
    do_div(16'h0064, 16'hFFF9, 1'b1, 0, "s100dm7");
    do_div(16'h8000, 16'hFFFF, 1'b1, 0, "s_ovf");
    chk("s_ovf_q_const", 32'(bus.quotient), 32'h8000);
    do_div(16'h8000, 16'hFFFF, 1'b0, 0, "u_ovf");
    do_div(16'h1234, 16'h0000, 1'b0, 0, "dz");
    do_div(16'h1234, 16'h0000, 1'b1, 0, "dz_signed");
    do_div(16'h0064, 16'h0007, 1'b0, 0, "dz_clear");
    do_div(16'hFFFF, 16'h0001, 1'b0, 6, "ignore_start");
    do_div(16'h8000, 16'h0001, 1'b1, 0, "s_min_d1");
    do_div(16'h0005, 16'h0007, 1'b1, 0, "s_small");

    // Reset in the middle of an iteration sequence
    @(negedge clk);
    bus.start = 1'b1; bus.signed_op = 1'b0; bus.dividend = 16'h0064; bus.divisor = 16'h0007;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_q", 32'(bus.quotient), 32'd0);
    chk("midrst_r", 32'(bus.remainder), 32'd0);
    chk("midrst_dz", 32'(bus.div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    chk("midrst_idle_after", 32'(saw_done), 32'd0);
    do_div(16'h0064, 16'h0007, 1'b0, 0, "post_rst");

    for (int n = 0; n < 30; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom);
      case ($urandom_range(0, 5))
        0: rb = 16'h0000;
        1: rb = 16'($urandom_range(1, 15));
        2: ra = 16'h8000;
        3: rb = 16'hFFFF;
        default: ;
      endcase
      do_div(ra, rb, rs, 0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
